// File: rtl/area_scan_accumulator.sv
// Sums SAMPLES_PER_SCAN consecutive area results into one per-scan total on a valid/ready output.
// Define AREA_ACC_MINMAX_EN to also report the per-scan minimum and maximum area.
module area_scan_accumulator #(
    parameter int AREA_W           = 26,
    parameter int SAMPLES_PER_SCAN = 4,
    parameter int SUM_W            = 32,
    parameter int CNT_W            = $clog2(SAMPLES_PER_SCAN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              scan_start,
    input  logic [AREA_W-1:0] area_in,
    input  logic              area_rdy,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [CNT_W-1:0]  sample_idx,
    output logic              busy,
    output logic              overrun
`ifdef AREA_ACC_MINMAX_EN
    ,
    output logic [AREA_W-1:0] area_min,
    output logic [AREA_W-1:0] area_max
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES_PER_SCAN - 1);
    localparam logic [CNT_W-1:0] FULL_IDX = CNT_W'(SAMPLES_PER_SCAN);

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               ovr_q, ovr_d;

    logic               start;
    logic               accept;
    logic               begin_scan;
    logic [SUM_W-1:0]   area_ext;
    logic [SUM_W-1:0]   acc_plus;

`ifdef AREA_ACC_MINMAX_EN
    logic [AREA_W-1:0]  run_min_q, run_min_d;
    logic [AREA_W-1:0]  run_max_q, run_max_d;
    logic [AREA_W-1:0]  min_out_q, min_out_d;
    logic [AREA_W-1:0]  max_out_q, max_out_d;
    logic [AREA_W-1:0]  upd_min;
    logic [AREA_W-1:0]  upd_max;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            ovr_q     <= 1'b0;
`ifdef AREA_ACC_MINMAX_EN
            run_min_q <= '0;
            run_max_q <= '0;
            min_out_q <= '0;
            max_out_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            ovr_q     <= ovr_d;
`ifdef AREA_ACC_MINMAX_EN
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            min_out_q <= min_out_d;
            max_out_q <= max_out_d;
`endif
        end
    end

    // A scan start (from IDLE, ACCUM, or DONE with handshake) is resolved per state,
    // then applied once at the end so a coincident sample always lands as sample 0.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        ovr_d      = ovr_q;
        begin_scan = 1'b0;
        start      = en && scan_start;
        accept     = en && area_rdy;
        area_ext   = SUM_W'(area_in);
        acc_plus   = acc_q + area_ext;
`ifdef AREA_ACC_MINMAX_EN
        run_min_d  = run_min_q;
        run_max_d  = run_max_q;
        min_out_d  = min_out_q;
        max_out_d  = max_out_q;
        upd_min    = (area_in < run_min_q) ? area_in : run_min_q;
        upd_max    = (area_in > run_max_q) ? area_in : run_max_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    begin_scan = 1'b1;
                end
            end
            ACCUM: begin
                if (start) begin
                    begin_scan = 1'b1;
                end else if (accept) begin
                    acc_d = acc_plus;
                    idx_d = idx_q + CNT_W'(1);
`ifdef AREA_ACC_MINMAX_EN
                    run_min_d = upd_min;
                    run_max_d = upd_max;
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        sum_d   = acc_plus;
                        idx_d   = FULL_IDX;
`ifdef AREA_ACC_MINMAX_EN
                        min_out_d = upd_min;
                        max_out_d = upd_max;
`endif
                    end
                end
            end
            DONE: begin
                if (sum_ready) begin
                    if (start) begin
                        begin_scan = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                if (accept && !(sum_ready && start)) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (begin_scan) begin
            state_d = ACCUM;
            ovr_d   = 1'b0;
            acc_d   = accept ? area_ext : '0;
            idx_d   = accept ? CNT_W'(1) : '0;
`ifdef AREA_ACC_MINMAX_EN
            run_min_d = accept ? area_in : '1;
            run_max_d = accept ? area_in : '0;
`endif
        end
    end

    assign sum_out    = sum_q;
    assign sum_valid  = (state_q == DONE);
    assign busy       = (state_q == ACCUM);
    assign sample_idx = idx_q;
    assign overrun    = ovr_q;
`ifdef AREA_ACC_MINMAX_EN
    assign area_min   = min_out_q;
    assign area_max   = max_out_q;
`endif

endmodule

// File: tb/tb_area_scan_accumulator.sv
// Scoreboard bench for area_scan_accumulator: expected totals are queued as scans are driven
// and popped when sum_valid appears. Min/max checks are built when AREA_ACC_MINMAX_EN is defined.
module tb_area_scan_accumulator;

    logic        clk;
    logic        rst;
    logic        en;
    logic        scan_start;
    logic [25:0] area_in;
    logic        area_rdy;
    logic [31:0] sum_out;
    logic        sum_valid;
    logic        sum_ready;
    logic [2:0]  sample_idx;
    logic        busy;
    logic        overrun;
`ifdef AREA_ACC_MINMAX_EN
    logic [25:0] area_min;
    logic [25:0] area_max;
`endif

    int n_cmp;
    int n_bad;
    logic [31:0] exp_q[$];
    logic [31:0] exp_sum;

    area_scan_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .scan_start (scan_start),
        .area_in    (area_in),
        .area_rdy   (area_rdy),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sample_idx (sample_idx),
        .busy       (busy),
        .overrun    (overrun)
`ifdef AREA_ACC_MINMAX_EN
        ,
        .area_min   (area_min),
        .area_max   (area_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        scan_start = 1'b1;
        cyc();
        scan_start = 1'b0;
    endtask

    task automatic feed(input logic [25:0] v);
        area_in  = v;
        area_rdy = 1'b1;
        cyc();
        area_rdy = 1'b0;
    endtask

    // Returns cycles spent before sum_valid was seen, or -1 if it never appeared.
    task automatic wait_valid(output int waited);
        waited = -1;
        for (int i = 0; i < 8; i++) begin
            if (sum_valid) begin
                waited = i;
                return;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (sum_out !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_sum: got %0d expected 0", sum_out); end
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b expected 0", sum_valid); end
        n_cmp++; if (sample_idx !== 3'd0) begin n_bad++; $display("[TB] FAIL reset_idx: got %0d expected 0", sample_idx); end
        n_cmp++; if (busy !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_flags: got busy=%b overrun=%b expected 0 0", busy, overrun); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        int w;
        sum_ready = 1'b1;
        pulse_start();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
        exp_q.push_back(32'd4000);
        feed(26'd1000);
        feed(26'd1000);
        n_cmp++; if (sample_idx !== 3'd2) begin n_bad++; $display("[TB] FAIL basic_idx: got %0d expected 2", sample_idx); end
        feed(26'd1000);
        feed(26'd1000);
        wait_valid(w);
        n_cmp++; if (w !== 0) begin n_bad++; $display("[TB] FAIL basic_latency: got %0d extra cycles expected 0", w); end
        exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++; if (sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL basic_sum: got %0d expected %0d", sum_out, exp_sum); end
        n_cmp++; if (sample_idx !== 3'd4 || overrun !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_done_state: got idx=%0d overrun=%b expected 4 0", sample_idx, overrun); end
        cyc();
        n_cmp++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_return_idle: got valid=%b busy=%b expected 0 0", sum_valid, busy); end
    endtask

    task automatic test_overrun();
        int w;
        sum_ready = 1'b0;
        pulse_start();
        exp_q.push_back(32'd4000);
        for (int i = 0; i < 4; i++) feed(26'd1000);
        wait_valid(w);
        n_cmp++; if (w !== 0) begin n_bad++; $display("[TB] FAIL ovr_latency: got %0d extra cycles expected 0", w); end
        exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++; if (sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL ovr_sum: got %0d expected %0d", sum_out, exp_sum); end
        feed(26'd50);
        for (int i = 0; i < 4; i++) cyc();
        n_cmp++; if (sum_valid !== 1'b1 || sum_out !== 32'd4000) begin n_bad++; $display("[TB] FAIL ovr_hold: got valid=%b sum=%0d expected 1 4000", sum_valid, sum_out); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); end
        sum_ready = 1'b1;
        cyc();
        sum_ready = 1'b0;
        n_cmp++; if (sum_valid !== 1'b0 || sum_out !== 32'd4000) begin n_bad++; $display("[TB] FAIL ovr_after_hs: got valid=%b sum=%0d expected 0 4000", sum_valid, sum_out); end
        cyc();
        cyc();
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun); end
        pulse_start();
        n_cmp++; if (overrun !== 1'b0 || busy !== 1'b1 || sample_idx !== 3'd0) begin n_bad++; $display("[TB] FAIL ovr_clear: got overrun=%b busy=%b idx=%0d expected 0 1 0", overrun, busy, sample_idx); end
    endtask

    task automatic test_max_value();
        int w;
        sum_ready = 1'b1;
        pulse_start();
        exp_q.push_back(32'h0FFF_FFFC);
        for (int i = 0; i < 4; i++) feed(26'h3FF_FFFF);
        wait_valid(w);
        exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++; if (w < 0 || sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL max_sum: got 0x%h (wait %0d) expected 0x%h", sum_out, w, exp_sum); end
        cyc();
    endtask

    task automatic test_restart();
        int w;
        sum_ready = 1'b1;
        pulse_start();
        feed(26'd9);
        feed(26'd9);
        exp_q.push_back(32'd28);
        scan_start = 1'b1;
        feed(26'd7);
        scan_start = 1'b0;
        n_cmp++; if (sample_idx !== 3'd1 || sum_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL restart_idx: got idx=%0d valid=%b expected 1 0", sample_idx, sum_valid); end
        for (int i = 0; i < 3; i++) feed(26'd7);
        wait_valid(w);
        exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++; if (w !== 0 || sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL restart_sum: got %0d (wait %0d) expected %0d", sum_out, w, exp_sum); end
        cyc();
    endtask

    task automatic test_enable_and_async_reset();
        int w;
        sum_ready = 1'b1;
        pulse_start();
        exp_q.push_back(32'd100);
        feed(26'd10);
        feed(26'd20);
        en = 1'b0;
        area_in  = 26'd100;
        area_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (sample_idx !== 3'd2 || busy !== 1'b1) begin n_bad++; $display("[TB] FAIL en_frozen_%0d: got idx=%0d busy=%b expected 2 1", i, sample_idx, busy); end
        end
        area_rdy = 1'b0;
        en = 1'b1;
        feed(26'd30);
        feed(26'd40);
        wait_valid(w);
        exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++; if (w !== 0 || sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL en_sum: got %0d (wait %0d) expected %0d", sum_out, w, exp_sum); end
        cyc();
        pulse_start();
        feed(26'd5);
        feed(26'd6);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (sum_out !== 32'd0 || sample_idx !== 3'd0 || busy !== 1'b0 || sum_valid !== 1'b0 || overrun !== 1'b0) begin
            n_bad++; $display("[TB] FAIL async_reset: got sum=%0d idx=%0d busy=%b valid=%b overrun=%b expected all 0", sum_out, sample_idx, busy, sum_valid, overrun);
        end
        cyc();
        rst = 1'b0;
        cyc();
        pulse_start();
        exp_q.push_back(32'd10);
        for (int i = 1; i <= 4; i++) feed(26'(i));
        wait_valid(w);
        exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++; if (w !== 0 || sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL post_reset_sum: got %0d (wait %0d) expected %0d", sum_out, w, exp_sum); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int w;
        sum_ready = 1'b1;
        pulse_start();
        exp_q.push_back(32'd44);
        for (int i = 0; i < 4; i++) feed(26'd11);
        wait_valid(w);
        exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++; if (w !== 0 || sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL b2b_first_sum: got %0d (wait %0d) expected %0d", sum_out, w, exp_sum); end
        exp_q.push_back(32'd26);
        scan_start = 1'b1;
        feed(26'd5);
        scan_start = 1'b0;
        n_cmp++; if (sum_valid !== 1'b0 || busy !== 1'b1 || sample_idx !== 3'd1 || overrun !== 1'b0) begin
            n_bad++; $display("[TB] FAIL b2b_restart: got valid=%b busy=%b idx=%0d overrun=%b expected 0 1 1 0", sum_valid, busy, sample_idx, overrun);
        end
        feed(26'd6);
        feed(26'd7);
        feed(26'd8);
        wait_valid(w);
        exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++; if (w !== 0 || sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL b2b_second_sum: got %0d (wait %0d) expected %0d", sum_out, w, exp_sum); end
        cyc();
    endtask

    task automatic test_minmax();
        int w;
        sum_ready = 1'b1;
        pulse_start();
        exp_q.push_back(32'd978);
        feed(26'd5);
        feed(26'd900);
        feed(26'd3);
        feed(26'd70);
        wait_valid(w);
        exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++; if (w !== 0 || sum_out !== exp_sum) begin n_bad++; $display("[TB] FAIL minmax_sum: got %0d (wait %0d) expected %0d", sum_out, w, exp_sum); end
`ifdef AREA_ACC_MINMAX_EN
        n_cmp++; if (area_min !== 26'd3) begin n_bad++; $display("[TB] FAIL minmax_min: got %0d expected 3", area_min); end
        n_cmp++; if (area_max !== 26'd900) begin n_bad++; $display("[TB] FAIL minmax_max: got %0d expected 900", area_max); end
`endif
        cyc();
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        en         = 1'b1;
        scan_start = 1'b0;
        area_in    = '0;
        area_rdy   = 1'b0;
        sum_ready  = 1'b0;

        test_reset();
        test_basic();
        test_overrun();
        test_max_value();
        test_restart();
        test_enable_and_async_reset();
        test_back_to_back();
        test_minmax();

        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
